// File: rtl/hash_pkg.sv
// Shared digest widths and sequencer state encoding for the digest-compare path.
package hash_pkg;
  localparam int unsigned DIGEST_N     = 32;
  localparam int unsigned DIGEST_WORDS = 8;
  localparam int unsigned DIGEST_IDX_W = $clog2(DIGEST_WORDS);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;
endpackage

// File: rtl/digest_match_seq_if.sv
// Target-load, word-stream and result signals of the digest match sequencer.
interface digest_match_seq_if;
  import hash_pkg::*;

  logic                    tgt_we_i;
  logic [DIGEST_IDX_W-1:0] tgt_addr_i;
  logic [DIGEST_N-1:0]     tgt_data_i;
  logic                    start_i;
  logic [DIGEST_N-1:0]     word_i;
  logic                    word_valid_i;
  logic                    word_ready_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    match_o;
  logic [DIGEST_IDX_W-1:0] mismatch_idx_o;

  modport master (
    output tgt_we_i, tgt_addr_i, tgt_data_i, start_i, word_i, word_valid_i,
    input  word_ready_o, busy_o, done_o, match_o, mismatch_idx_o
  );

  modport slave (
    input  tgt_we_i, tgt_addr_i, tgt_data_i, start_i, word_i, word_valid_i,
    output word_ready_o, busy_o, done_o, match_o, mismatch_idx_o
  );
endinterface

// File: rtl/word_eq_cmp.sv
// Combinational W-bit equality comparator.
module word_eq_cmp #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  output logic         eq_c_o
);
  assign eq_c_o = (a_i == b_i);
endmodule

// File: rtl/digest_match_seq.sv
// Streams computed digest words against a stored target digest and reports
// an overall match flag plus the index of the first unequal word.
module digest_match_seq
  import hash_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  digest_match_seq_if.slave  bus_if
);
  localparam int unsigned N     = DIGEST_N;
  localparam int unsigned WORDS = DIGEST_WORDS;
  localparam int unsigned IDX_W = DIGEST_IDX_W;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [IDX_W-1:0] mm_idx_q, mm_idx_d;
  logic             acc_q, acc_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic             busy_q, busy_d;
  logic             ready_q, ready_d;
  logic [N-1:0]     tgt_q [WORDS];
  logic             eq_c;
  logic             hs_c;
  logic             last_c;

  word_eq_cmp #(.W(N)) u_word_eq_cmp (
    .a_i    (bus_if.word_i),
    .b_i    (tgt_q[cnt_q]),
    .eq_c_o (eq_c)
  );

  assign hs_c   = bus_if.word_valid_i & ready_q;
  assign last_c = (cnt_q == IDX_W'(WORDS - 1));

  // Target store only accepts writes while idle so a run sees a stable digest.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(WORDS); i++) tgt_q[i] <= '0;
    end else if (bus_if.tgt_we_i && (state_q == IDLE)) begin
      tgt_q[bus_if.tgt_addr_i] <= bus_if.tgt_data_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      mm_idx_q <= '0;
      acc_q    <= 1'b0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      mm_idx_q <= mm_idx_d;
      acc_q    <= acc_d;
      match_q  <= match_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
    end
  end

  // Result is committed with the last handshake so it is valid alongside Done.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    mm_idx_d = mm_idx_q;
    acc_d    = acc_q;
    match_d  = match_q;
    done_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus_if.start_i) begin
          state_d  = RUN;
          cnt_d    = '0;
          idx_d    = '0;
          acc_d    = 1'b1;
          match_d  = 1'b0;
          mm_idx_d = '0;
        end
      end
      RUN: begin
        if (hs_c) begin
          acc_d = acc_q & eq_c;
          if (!eq_c && acc_q) idx_d = cnt_q;
          cnt_d = cnt_q + IDX_W'(1);
          if (last_c) begin
            state_d  = DONE;
            done_d   = 1'b1;
            match_d  = acc_d;
            mm_idx_d = acc_d ? '0 : idx_d;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy_d  = (state_d != IDLE);
  assign ready_d = (state_d == RUN);

  assign bus_if.word_ready_o   = ready_q;
  assign bus_if.busy_o         = busy_q;
  assign bus_if.done_o         = done_q;
  assign bus_if.match_o        = match_q;
  assign bus_if.mismatch_idx_o = mm_idx_q;
endmodule
